// File: rtl/rtc_time_base_if.sv
// Bundles the time-of-day block's control inputs and time/pulse outputs.
// master drives the buttons and load path; slave is the time base itself.
// Pure wiring: no state, no latency.
interface rtc_time_base_if;
    logic       run_en;
    logic       mode_btn;
    logic       inc_btn;
    logic       load;
    logic [7:0] load_hr;
    logic [7:0] load_min;
    logic [7:0] hr;
    logic [7:0] min;
    logic [1:0] mode;
    logic       min_tick;
    logic       day_tick;
    logic       load_err;

    modport master (
        output run_en, mode_btn, inc_btn, load, load_hr, load_min,
        input  hr, min, mode, min_tick, day_tick, load_err
    );

    modport slave (
        input  run_en, mode_btn, inc_btn, load, load_hr, load_min,
        output hr, min, mode, min_tick, day_tick, load_err
    );
endinterface

// File: rtl/rtc_time_base.sv
// Time-of-day generator: prescaled minute/hour counter with button set mode and bulk load.
// Latency: all outputs registered, one cycle after the causing input is sampled.
// No backpressure: every input event is acted on (or discarded by priority) in the cycle it is sampled.
module rtc_time_base #(
    parameter int TICKS_PER_MIN = 60,
    parameter int PRESC_W       = 8
) (
    input logic         clk,
    input logic         rst,
    rtc_time_base_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_MIN - 1);

    mode_e              state_q;
    logic [PRESC_W-1:0] presc_q;
    logic [7:0]         hr_q;
    logic [7:0]         min_q;
    logic               mode_btn_q;
    logic               inc_btn_q;
    logic               min_tick_q;
    logic               day_tick_q;
    logic               load_err_q;

    logic               mode_edge;
    logic               inc_edge;
    logic               load_ok;
    logic               count_en;
    logic               presc_wrap;
    logic [7:0]         hr_step;
    logic [7:0]         min_step;

    // Rising edge acts in the same cycle the high level is first sampled.
    assign mode_edge  = bus.mode_btn & ~mode_btn_q;
    assign inc_edge   = bus.inc_btn & ~inc_btn_q;
    assign load_ok    = (bus.load_hr <= 8'd23) && (bus.load_min <= 8'd59);
    assign count_en   = (state_q == RUN) && bus.run_en;
    assign presc_wrap = (presc_q == PRESC_LAST);
    // Wrapping increments keep hr/min inside their legal ranges.
    assign hr_step    = (hr_q  == 8'd23) ? 8'd0 : hr_q  + 8'd1;
    assign min_step   = (min_q == 8'd59) ? 8'd0 : min_q + 8'd1;

    // Button history; reset high so a button held through reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_btn_q <= 1'b1;
            inc_btn_q  <= 1'b1;
        end else begin
            mode_btn_q <= bus.mode_btn;
            inc_btn_q  <= bus.inc_btn;
        end
    end

    // Mode FSM, time registers and pulses: load > mode edge > inc edge > prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            presc_q    <= '0;
            hr_q       <= 8'd0;
            min_q      <= 8'd0;
            min_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            min_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    hr_q    <= bus.load_hr;
                    min_q   <= bus.load_min;
                    presc_q <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (mode_edge) begin
                // Prescaler is zero in SET modes and restarts on return to RUN.
                presc_q <= '0;
                case (state_q)
                    RUN:     state_q <= SET_HR;
                    SET_HR:  state_q <= SET_MIN;
                    default: state_q <= RUN;
                endcase
            end else if (inc_edge && (state_q != RUN)) begin
                // Setting a field never carries and never pulses the ticks.
                if (state_q == SET_HR) begin
                    hr_q <= hr_step;
                end else begin
                    min_q <= min_step;
                end
            end else if (count_en) begin
                if (presc_wrap) begin
                    presc_q    <= '0;
                    min_q      <= min_step;
                    min_tick_q <= 1'b1;
                    if (min_q == 8'd59) begin
                        hr_q <= hr_step;
                        if (hr_q == 8'd23) begin
                            day_tick_q <= 1'b1;
                        end
                    end
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end else if (state_q != RUN) begin
                presc_q <= '0;
            end
        end
    end

    assign bus.hr       = hr_q;
    assign bus.min      = min_q;
    assign bus.mode     = state_q;
    assign bus.min_tick = min_tick_q;
    assign bus.day_tick = day_tick_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_rtc_time_base.sv
// Directed bench for rtc_time_base with TICKS_PER_MIN=4.
module tb_rtc_time_base;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ticks_seen = 0;

    rtc_time_base_if bus ();

    rtc_time_base #(.TICKS_PER_MIN(4), .PRESC_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; sample 1 time unit after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.min_tick) ticks_seen++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.inc_btn = 1'b1; step(1);
            bus.inc_btn = 1'b0; step(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.run_en = 1'b0; bus.mode_btn = 1'b0; bus.inc_btn = 1'b0;
        bus.load = 1'b0; bus.load_hr = 8'd0; bus.load_min = 8'd0;

        // Reset state
        #3;
        chk("rst_hr", bus.hr, 0);
        chk("rst_min", bus.min, 0);
        chk("rst_mode", bus.mode, 0);
        chk("rst_pulses", {bus.min_tick, bus.day_tick, bus.load_err}, 0);
        @(negedge clk); rst = 1'b0;
        step(1);

        // 1: free run for 12 cycles, minute every 4 cycles
        ticks_seen = 0;
        bus.run_en = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step(1);
            chk("t1_min", bus.min, c / 4);
            chk("t1_tick", bus.min_tick, (c % 4 == 0) ? 1 : 0);
        end
        chk("t1_hr", bus.hr, 0);
        chk("t1_tick_count", ticks_seen, 3);
        bus.run_en = 1'b0;

        // 2: load 23:59 then roll over the day
        bus.load = 1'b1; bus.load_hr = 8'd23; bus.load_min = 8'd59;
        step(1);
        bus.load = 1'b0;
        chk("t2_load_hr", bus.hr, 23);
        chk("t2_load_min", bus.min, 59);
        chk("t2_load_notick", bus.min_tick, 0);
        bus.run_en = 1'b1;
        step(3);
        chk("t2_pre_min", bus.min, 59);
        chk("t2_pre_day", bus.day_tick, 0);
        step(1);
        chk("t2_hr", bus.hr, 0);
        chk("t2_min", bus.min, 0);
        chk("t2_min_tick", bus.min_tick, 1);
        chk("t2_day_tick", bus.day_tick, 1);
        step(1);
        chk("t2_pulses_off", {bus.min_tick, bus.day_tick}, 0);
        bus.run_en = 1'b0;

        // 3: rejected load, then accepted load, then hold with run_en low
        bus.load = 1'b1; bus.load_hr = 8'd24; bus.load_min = 8'd10;
        step(1);
        bus.load = 1'b0;
        chk("t3_bad_hr", bus.hr, 0);
        chk("t3_bad_min", bus.min, 0);
        chk("t3_err", bus.load_err, 1);
        step(1);
        chk("t3_err_off", bus.load_err, 0);
        bus.load = 1'b1; bus.load_hr = 8'd5; bus.load_min = 8'd5;
        step(1);
        bus.load = 1'b0;
        chk("t3_hr", bus.hr, 5);
        chk("t3_min", bus.min, 5);
        chk("t3_err_ok", bus.load_err, 0);
        step(6);
        chk("t3_hold_min", bus.min, 5);

        // 4: set mode from 22:58 with run_en high throughout
        bus.load = 1'b1; bus.load_hr = 8'd22; bus.load_min = 8'd58;
        step(1);
        bus.load = 1'b0;
        bus.run_en = 1'b1;
        ticks_seen = 0;
        bus.mode_btn = 1'b1; step(1);
        chk("t4_mode_sethr", bus.mode, 1);
        bus.mode_btn = 1'b0; step(1);
        press_inc(3);
        chk("t4_hr_set", bus.hr, 1);
        chk("t4_min_kept", bus.min, 58);
        bus.mode_btn = 1'b1; step(1);
        chk("t4_mode_setmin", bus.mode, 2);
        bus.mode_btn = 1'b0; step(1);
        press_inc(61);
        chk("t4_min_set", bus.min, 59);
        chk("t4_hr_nocarry", bus.hr, 1);
        chk("t4_no_ticks", ticks_seen, 0);
        bus.mode_btn = 1'b1; step(1);
        chk("t4_mode_run", bus.mode, 0);
        bus.mode_btn = 1'b0;
        step(3);
        chk("t4_full_period_min", bus.min, 59);
        step(1);
        chk("t4_adv_hr", bus.hr, 2);
        chk("t4_adv_min", bus.min, 0);
        chk("t4_adv_tick", bus.min_tick, 1);
        bus.run_en = 1'b0;

        // 5: load beats mode edge; mode edge beats inc edge
        bus.load = 1'b1; bus.load_hr = 8'd7; bus.load_min = 8'd30; bus.mode_btn = 1'b1;
        step(1);
        bus.load = 1'b0;
        chk("t5_load_hr", bus.hr, 7);
        chk("t5_load_min", bus.min, 30);
        chk("t5_mode_kept", bus.mode, 0);
        bus.mode_btn = 1'b0; step(1);
        bus.mode_btn = 1'b1; bus.inc_btn = 1'b1; step(1);
        chk("t5_mode_adv", bus.mode, 1);
        chk("t5_hr_kept", bus.hr, 7);
        bus.mode_btn = 1'b0; bus.inc_btn = 1'b0; step(1);
        press_inc(1);
        chk("t5_hr_inc", bus.hr, 8);
        bus.mode_btn = 1'b1; step(1);
        bus.mode_btn = 1'b0; step(1);
        press_inc(1);
        chk("t5_min_inc", bus.min, 31);
        chk("t5_in_setmin", bus.mode, 2);

        // 6: async reset from SET_MIN
        rst = 1'b1;
        #1;
        chk("t6_rst_hr", bus.hr, 0);
        chk("t6_rst_min", bus.min, 0);
        chk("t6_rst_mode", bus.mode, 0);
        @(negedge clk); rst = 1'b0;
        step(1);
        // run partway into a minute, then reset with mode_btn held across release
        bus.run_en = 1'b1;
        step(2);
        chk("t6_mid_min", bus.min, 0);
        rst = 1'b1; bus.mode_btn = 1'b1;
        #1;
        chk("t6_rst2_pulses", {bus.min_tick, bus.day_tick, bus.load_err}, 0);
        @(negedge clk); rst = 1'b0;
        step(3);
        chk("t6_presc_cleared_min", bus.min, 0);
        chk("t6_held_btn_mode", bus.mode, 0);
        step(1);
        chk("t6_first_min", bus.min, 1);
        chk("t6_first_tick", bus.min_tick, 1);
        chk("t6_mode_still_run", bus.mode, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
